// File: rtl/io_buffer.sv
// Memory-mapped I/O block behind the LSU decoder: output-device registers,
// synchronized switch inputs and debounced push-button inputs.
module io_buffer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SW_W            = 18
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_io_valid,
  input  logic [31:0]     i_lsu_addr,
  input  logic            i_lsu_wren,
  input  logic [3:0]      i_bmask,
  input  logic [31:0]     i_st_data,
  input  logic [SW_W-1:0] i_sw,
  input  logic [3:0]      i_key,
  output logic [31:0]     o_ld_data,
  output logic [31:0]     o_io_ledr,
  output logic [31:0]     o_io_ledg,
  output logic [6:0]      o_io_hex0,
  output logic [6:0]      o_io_hex1,
  output logic [6:0]      o_io_hex2,
  output logic [6:0]      o_io_hex3,
  output logic [6:0]      o_io_hex4,
  output logic [6:0]      o_io_hex5,
  output logic [6:0]      o_io_hex6,
  output logic [6:0]      o_io_hex7,
  output logic [31:0]     o_io_lcd
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] SEL_LEDR   = 4'd0;
  localparam logic [3:0] SEL_LEDG   = 4'd1;
  localparam logic [3:0] SEL_HEX_LO = 4'd2;
  localparam logic [3:0] SEL_HEX_HI = 4'd3;
  localparam logic [3:0] SEL_LCD    = 4'd4;
  localparam logic [3:0] SEL_SW     = 4'd0;
  localparam logic [3:0] SEL_KEY    = 4'd1;

  logic            region_in;
  logic [3:0]      sel;
  logic            wr_en;
  logic [31:0]     byte_en;

  logic [31:0]     ledr;
  logic [31:0]     ledg;
  logic [31:0]     lcd;
  logic [7:0][6:0] hex;

  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;
  logic [3:0]      key_meta;
  logic [3:0]      key_sync;
  logic [3:0]      key_stable;
  logic [3:0][CNT_W-1:0] key_cnt;

  logic [31:0]     sw_ext;
  logic [31:0]     hex_lo_rd;
  logic [31:0]     hex_hi_rd;

  // Address bits outside the region/select fields are decoded upstream.
  logic unused_addr;
  assign unused_addr = ^{i_lsu_addr[31:17], i_lsu_addr[11:0]};

  assign region_in = i_lsu_addr[16];
  assign sel       = i_lsu_addr[15:12];
  assign wr_en     = i_io_valid & i_lsu_wren & ~region_in;

  always_comb begin
    byte_en = '0;
    for (int k = 0; k < 4; k++) begin
      byte_en[8*k +: 8] = {8{i_bmask[k]}};
    end
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] be);
    return (old_val & ~be) | (new_val & be);
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ledr <= '0;
      ledg <= '0;
      lcd  <= '0;
      hex  <= '0;
    end else if (wr_en) begin
      case (sel)
        SEL_LEDR: ledr <= merge_bytes(ledr, i_st_data, byte_en);
        SEL_LEDG: ledg <= merge_bytes(ledg, i_st_data, byte_en);
        SEL_HEX_LO: begin
          for (int k = 0; k < 4; k++) begin
            if (i_bmask[k]) hex[k] <= i_st_data[8*k +: 7];
          end
        end
        SEL_HEX_HI: begin
          for (int k = 0; k < 4; k++) begin
            if (i_bmask[k]) hex[k+4] <= i_st_data[8*k +: 7];
          end
        end
        SEL_LCD:  lcd <= merge_bytes(lcd, i_st_data, byte_en);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      sw_meta  <= i_sw;
      sw_sync  <= sw_meta;
      key_meta <= i_key;
      key_sync <= key_meta;
    end
  end

  // Stable value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      key_stable <= '0;
      key_cnt    <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (key_sync[b] == key_stable[b]) begin
          key_cnt[b] <= '0;
        end else if (key_cnt[b] == CNT_LAST) begin
          key_stable[b] <= key_sync[b];
          key_cnt[b]    <= '0;
        end else begin
          key_cnt[b] <= key_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    sw_ext = '0;
    sw_ext[SW_W-1:0] = sw_sync;
  end

  always_comb begin
    hex_lo_rd = '0;
    hex_hi_rd = '0;
    for (int k = 0; k < 4; k++) begin
      hex_lo_rd[8*k +: 8] = {1'b0, hex[k]};
      hex_hi_rd[8*k +: 8] = {1'b0, hex[k+4]};
    end
  end

  always_comb begin
    o_ld_data = '0;
    if (i_io_valid) begin
      if (!region_in) begin
        case (sel)
          SEL_LEDR:   o_ld_data = ledr;
          SEL_LEDG:   o_ld_data = ledg;
          SEL_HEX_LO: o_ld_data = hex_lo_rd;
          SEL_HEX_HI: o_ld_data = hex_hi_rd;
          SEL_LCD:    o_ld_data = lcd;
          default:    o_ld_data = '0;
        endcase
      end else begin
        case (sel)
          SEL_SW:  o_ld_data = sw_ext;
          SEL_KEY: o_ld_data = {28'd0, key_stable};
          default: o_ld_data = '0;
        endcase
      end
    end
  end

  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_lcd  = lcd;
  assign o_io_hex0 = hex[0];
  assign o_io_hex1 = hex[1];
  assign o_io_hex2 = hex[2];
  assign o_io_hex3 = hex[3];
  assign o_io_hex4 = hex[4];
  assign o_io_hex5 = hex[5];
  assign o_io_hex6 = hex[6];
  assign o_io_hex7 = hex[7];

endmodule

// File: tb/tb_io_buffer.sv
// Directed plus randomized checks of io_buffer against a transaction-level
// model of the register map, input synchronizers and key debounce.
module tb_io_buffer;

  localparam int DEB  = 4;
  localparam int SW_W = 18;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_io_valid;
  logic [31:0]     i_lsu_addr;
  logic            i_lsu_wren;
  logic [3:0]      i_bmask;
  logic [31:0]     i_st_data;
  logic [SW_W-1:0] i_sw;
  logic [3:0]      i_key;
  logic [31:0]     o_ld_data;
  logic [31:0]     o_io_ledr;
  logic [31:0]     o_io_ledg;
  logic [6:0]      o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
  logic [6:0]      o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;
  logic [31:0]     o_io_lcd;

  io_buffer #(.DEBOUNCE_CYCLES(DEB), .SW_W(SW_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_io_valid(i_io_valid),
    .i_lsu_addr(i_lsu_addr), .i_lsu_wren(i_lsu_wren), .i_bmask(i_bmask),
    .i_st_data(i_st_data), .i_sw(i_sw), .i_key(i_key), .o_ld_data(o_ld_data),
    .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg),
    .o_io_hex0(o_io_hex0), .o_io_hex1(o_io_hex1), .o_io_hex2(o_io_hex2),
    .o_io_hex3(o_io_hex3), .o_io_hex4(o_io_hex4), .o_io_hex5(o_io_hex5),
    .o_io_hex6(o_io_hex6), .o_io_hex7(o_io_hex7), .o_io_lcd(o_io_lcd)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0]     m_ledr, m_ledg, m_hexlo, m_hexhi, m_lcd;
  logic [SW_W-1:0] sw_d1, sw_d2;
  logic [3:0]      key_d1, key_d2, m_key;
  logic [3:0]      kwin[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bytes_of(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = m[k] ? 8'hFF : 8'h00;
    return r;
  endfunction

  function automatic logic [31:0] exp_rd();
    if (!i_io_valid) return 32'h0;
    if (!i_lsu_addr[16]) begin
      case (i_lsu_addr[15:12])
        4'd0: return m_ledr;
        4'd1: return m_ledg;
        4'd2: return m_hexlo;
        4'd3: return m_hexhi;
        4'd4: return m_lcd;
        default: return 32'h0;
      endcase
    end
    case (i_lsu_addr[15:12])
      4'd0: return 32'(sw_d2);
      4'd1: return {28'd0, m_key};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ledr = '0; m_ledg = '0; m_hexlo = '0; m_hexhi = '0; m_lcd = '0;
    sw_d1 = '0; sw_d2 = '0; key_d1 = '0; key_d2 = '0; m_key = '0;
    kwin.delete();
  endtask

  // One rising edge: masked store, pins seen two edges late, and a key bit
  // flips once its last DEB synchronized samples all disagree with it.
  task automatic model_edge();
    logic [31:0] be;
    bit all_diff;
    if (i_io_valid && i_lsu_wren && !i_lsu_addr[16]) begin
      be = bytes_of(i_bmask);
      case (i_lsu_addr[15:12])
        4'd0: m_ledr  = (m_ledr & ~be) | (i_st_data & be);
        4'd1: m_ledg  = (m_ledg & ~be) | (i_st_data & be);
        4'd2: m_hexlo = ((m_hexlo & ~be) | (i_st_data & be)) & 32'h7F7F7F7F;
        4'd3: m_hexhi = ((m_hexhi & ~be) | (i_st_data & be)) & 32'h7F7F7F7F;
        4'd4: m_lcd   = (m_lcd & ~be) | (i_st_data & be);
        default: ;
      endcase
    end
    kwin.push_back(key_d2);
    if (kwin.size() > DEB) void'(kwin.pop_front());
    sw_d2 = sw_d1;  sw_d1 = i_sw;
    key_d2 = key_d1; key_d1 = i_key;
    if (kwin.size() == DEB) begin
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        foreach (kwin[i]) if (kwin[i][b] == m_key[b]) all_diff = 1'b0;
        if (all_diff) m_key[b] = ~m_key[b];
      end
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    i_io_valid = 1'b1; i_lsu_wren = 1'b1;
    i_lsu_addr = addr; i_st_data = data; i_bmask = mask;
    #1;
    step();
    i_lsu_wren = 1'b0;
    #1;
  endtask

  task automatic read_at(input logic [31:0] addr);
    i_io_valid = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = addr;
    #1;
  endtask

  task automatic chk_outputs();
    chk("ledr", o_io_ledr, m_ledr);
    chk("ledg", o_io_ledg, m_ledg);
    chk("lcd",  o_io_lcd,  m_lcd);
    chk("hex0", 32'(o_io_hex0), 32'(m_hexlo[6:0]));
    chk("hex1", 32'(o_io_hex1), 32'(m_hexlo[14:8]));
    chk("hex2", 32'(o_io_hex2), 32'(m_hexlo[22:16]));
    chk("hex3", 32'(o_io_hex3), 32'(m_hexlo[30:24]));
    chk("hex4", 32'(o_io_hex4), 32'(m_hexhi[6:0]));
    chk("hex5", 32'(o_io_hex5), 32'(m_hexhi[14:8]));
    chk("hex6", 32'(o_io_hex6), 32'(m_hexhi[22:16]));
    chk("hex7", 32'(o_io_hex7), 32'(m_hexhi[30:24]));
  endtask

  initial begin
    i_reset = 1'b0; i_io_valid = 1'b0; i_lsu_addr = '0; i_lsu_wren = 1'b0;
    i_bmask = '0; i_st_data = '0; i_sw = '0; i_key = '0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ledr", o_io_ledr, 32'h0);
    chk("rst_hex0", 32'(o_io_hex0), 32'h0);
    i_reset = 1'b1;
    read_at(32'h1000_0000);
    chk("rst_rd", o_ld_data, 32'h0);
    chk_outputs();

    // Byte-masked LEDR stores.
    store(32'h1000_0000, 32'hDEAD_BEEF, 4'b1111);
    store(32'h1000_0000, 32'h0000_0011, 4'b0001);
    chk("ledr_mask", o_io_ledr, 32'hDEAD_BE11);

    // HEX storage keeps 7 bits per byte.
    store(32'h1000_2000, 32'hFF80_7F01, 4'b1111);
    chk("hex3_c", 32'(o_io_hex3), 32'h7F);
    chk("hex2_c", 32'(o_io_hex2), 32'h00);
    chk("hex1_c", 32'(o_io_hex1), 32'h7F);
    chk("hex0_c", 32'(o_io_hex0), 32'h01);
    read_at(32'h1000_2000);
    chk("hex_rd", o_ld_data, 32'h7F00_7F01);

    // Read during write returns the old value.
    i_lsu_addr = 32'h1000_0000; i_lsu_wren = 1'b1; i_st_data = 32'h1234_5678; i_bmask = 4'hF;
    #1;
    chk("rdw_old", o_ld_data, 32'hDEAD_BE11);
    step();
    i_lsu_wren = 1'b0;
    #1;
    chk("rdw_new", o_ld_data, 32'h1234_5678);

    // Switch synchronizer latency.
    read_at(32'h1001_0000);
    i_sw = 18'h2A5A5;
    #1;
    chk("sw_e0", o_ld_data, 32'h0);
    step();
    chk("sw_e1", o_ld_data, 32'h0);
    step();
    chk("sw_e2", o_ld_data, 32'h0002_A5A5);
    chk("sw_model", o_ld_data, exp_rd());

    // Short key glitch is rejected.
    read_at(32'h1001_1000);
    i_key = 4'b0001;
    step(); step();
    i_key = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("key_glitch", o_ld_data, 32'h0);
    end

    // Held key appears after 2+DEB edges.
    i_key = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("key_hold", o_ld_data, (i == 6) ? 32'h1 : 32'h0);
      chk("key_model", o_ld_data, exp_rd());
    end

    // Stores ignored without valid, to the input region, or when unmapped.
    store(32'h1000_1000, 32'h0000_0005, 4'hF);
    i_io_valid = 1'b0; i_lsu_wren = 1'b1; i_lsu_addr = 32'h1000_1000;
    i_st_data = 32'hFFFF_FFFF; i_bmask = 4'hF;
    #1;
    chk("novalid_rd", o_ld_data, 32'h0);
    step();
    i_lsu_wren = 1'b0;
    chk("novalid_ledg", o_io_ledg, 32'h5);
    store(32'h1001_0000, 32'h0000_0000, 4'hF);
    read_at(32'h1001_0000);
    chk("sw_nowrite", o_ld_data, 32'h0002_A5A5);
    store(32'h1000_7000, 32'hA5A5_A5A5, 4'hF);
    chk_outputs();
    read_at(32'h1000_7000);
    chk("unmapped_out", o_ld_data, 32'h0);
    read_at(32'h1001_2000);
    chk("unmapped_in", o_ld_data, 32'h0);

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      i_io_valid = ($urandom_range(0, 7) != 0);
      i_lsu_wren = 1'($urandom_range(0, 1));
      i_lsu_addr = {15'h0800, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 12'($urandom)};
      i_st_data  = $urandom;
      i_bmask    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) i_sw = SW_W'($urandom);
      if ($urandom_range(0, 5) == 0) i_key = 4'($urandom);
      #1;
      chk("rnd_ld", o_ld_data, exp_rd());
      step();
      chk_outputs();
    end

    // Asynchronous reset mid-cycle, mid-debounce; keys idle high afterwards.
    store(32'h1000_1000, 32'h0000_0005, 4'hF);
    chk("ledg5", o_io_ledg, 32'h5);
    read_at(32'h1001_1000);
    i_key = 4'hF;
    step(); step(); step();
    #3;
    i_reset = 1'b0;
    #1;
    model_reset();
    chk("async_ledg", o_io_ledg, 32'h0);
    chk("async_key", o_ld_data, 32'h0);
    chk_outputs();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    #1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("key_settle", o_ld_data, (i == 6) ? 32'hF : 32'h0);
      chk("key_settle_model", o_ld_data, exp_rd());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/io_buffer.md
Name: io_buffer

Overview:
- Memory-mapped I/O peripheral block, directly downstream of the LSU address decoder.
- Accepts the decoder's I/O-region valid flag together with the LSU address, store data, write enable and byte mask.
- Holds the output-device registers (LEDR, LEDG, HEX0-7, LCD) and returns load data for both output and input regions.
- Input pins (switches, keys) pass through a 2-flop synchronizer; keys are additionally debounced.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized key must differ from its stable value before the stable value updates; must be >= 1
SW_W, 18, number of switch inputs; must be <= 32

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_io_valid  in  1  decoder flag: address lies in the 0x1000_xxxx / 0x1001_xxxx region
i_lsu_addr  in  32  load/store address
i_lsu_wren  in  1  store request
i_bmask  in  4  byte-enable mask, bit k covers bits [8k+7:8k]
i_st_data  in  32  store data
i_sw  in  SW_W  raw switch pins, asynchronous
i_key  in  4  raw push-button pins, asynchronous
o_ld_data  out  32  load data, combinational
o_io_ledr  out  32  red LED register
o_io_ledg  out  32  green LED register
o_io_hex0..o_io_hex7  out  7 each  seven-segment digit registers
o_io_lcd  out  32  LCD control/data register

Behaviour:
- Register select: addr[16] selects the region (0 = output, 1 = input); addr[15:12] selects the register; addr[11:0] is ignored.
- Output region (addr[16]=0), addr[15:12] map:
  - 0 = LEDR
  - 1 = LEDG
  - 2 = HEX_LO, byte k drives hex k, k=0..3
  - 3 = HEX_HI, byte k drives hex k+4
  - 4 = LCD
- Input region (addr[16]=1), addr[15:12] map:
  - 0 = SW, zero-extended
  - 1 = KEY, debounced, bits [3:0]
- Any other offset is unmapped: reads return 0, writes are ignored.
- Write timing: a write occurs at the rising edge when i_io_valid && i_lsu_wren. Only bytes with i_bmask[k]=1 update. Writes to the input region are ignored.
- HEX storage: only bits [6:0] of each byte are stored. Reads of HEX_LO/HEX_HI return bit 7 of every byte as 0.
- Read path:
  - o_ld_data = selected register when i_io_valid = 1, else 0. No byte masking; the LSU extracts the bytes it needs.
  - Read-during-write to the same register returns the pre-edge value; the new value is visible after the edge.
- Switch path: 2-flop synchronizer per bit. A pin change is visible in SW reads after exactly 2 rising edges.
- Key debounce, per bit, using a counter of width clog2(DEBOUNCE_CYCLES)+1:
  - If synced == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0.
  - Else: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never reaches stable.
  - A clean pin change is visible in KEY reads after 2+DEBOUNCE_CYCLES rising edges.
- Reset (asynchronous assert, i_reset=0):
  - All output registers, synchronizer flops, stable key values and counters are 0.
  - o_ld_data follows the combinational rule.
  - Reset asserted mid-debounce discards the count.
  - After release, idle-high keys settle to 1 after 2+DEBOUNCE_CYCLES edges.
- Stores with i_io_valid=0 never modify any register, even if the address bits match.

Test Plan:
- Reset release, no stores -> all outputs 0. Read of 0x1000_0000 returns 0x0000_0000.
- Store 0xDEADBEEF to 0x1000_0000 with mask 4'b1111, then 0x0000_0011 with mask 4'b0001 -> o_io_ledr = 0xDEADBE11.
- Store 0xFF80_7F01 to 0x1000_2000 with mask 4'b1111:
  - o_io_hex3 = 7'h7F, o_io_hex2 = 7'h00, o_io_hex1 = 7'h7F, o_io_hex0 = 7'h01.
  - Readback returns 0x7F00_7F01.
- i_sw = 18'h2A5A5 changed before edge 0 -> read of 0x1001_0000 returns 0x0002_A5A5 from edge 2 onward.
- i_key[0] pulsed high for 2 cycles (DEBOUNCE_CYCLES=4) -> KEY read stays 0.
- i_key[0] held high -> KEY read bit 0 becomes 1 exactly 6 edges after the change.
- Store with i_io_valid=0 to 0x1000_1000 -> o_io_ledg unchanged.
- Store to 0x1001_0000 -> SW read unaffected.
- Read of 0x1000_7000 -> returns 0.
- i_reset asserted mid-cycle after LEDG = 0x5 -> o_io_ledg = 0 immediately, without waiting for a clock edge.
